// File: rtl/stepped_cpu_core.sv
// stepped_cpu_core: operator-stepped CPU with a parametrised register file.
// Opcode, A and B are latched from the switches on three Step presses.
// A fourth press executes. MUL runs as a DATA_W-cycle shift-add sequence.
module stepped_cpu_core #(
  parameter int DATA_W = 4,
  parameter int NREG   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Step,
  input  logic                  Clear,
  input  logic                  Show,
  input  logic [DATA_W-1:0]     Sw,
  output logic [1:0]            Phase,
  output logic                  Busy,
  output logic                  Done,
  output logic [3:0]            Flags,
  output logic [2*DATA_W-1:0]   Result,
  output logic [2*DATA_W-1:0]   Result_Disp
);

  localparam int IDX_W = $clog2(NREG);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [2:0] {
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_MUL
  } state_t;

  state_t                state_q, state_d;
  logic                  stepPrev_q;
  logic                  done_q, done_d;
  logic [3:0]            flags_q, flags_d;
  logic                  lastMul_q, lastMul_d;
  logic [DATA_W-1:0]     regs_q [NREG];
  logic [DATA_W-1:0]     regs_d [NREG];
  logic [2*DATA_W-1:0]   mulAcc_q, mulAcc_d;
  logic [2*DATA_W-1:0]   mulCand_q, mulCand_d;
  logic [DATA_W-1:0]     mulPlier_q, mulPlier_d;
  logic [CNT_W-1:0]      mulCnt_q, mulCnt_d;

  logic                  stepEvent;
  logic [3:0]            opc;
  logic [DATA_W-1:0]     opA, opB;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W:0]       sumW;
  logic [DATA_W-1:0]     diffW;
  logic [2*DATA_W-1:0]   mulAdd;
  logic [DATA_W-1:0]     aluRes;
  logic                  aluV, aluC;

  // Operands always come from R0..R2; the step edge is ignored while multiplying
  always_comb begin
    stepEvent = Step && !stepPrev_q && (state_q != ST_MUL);
    opc       = regs_q[0][3:0];
    opA       = regs_q[1];
    opB       = regs_q[2];
    idx       = regs_q[1][IDX_W-1:0];
    sumW      = {1'b0, opA} + {1'b0, opB};
    diffW     = opA - opB;
    mulAdd    = mulPlier_q[0] ? (mulAcc_q + mulCand_q) : mulAcc_q;
  end

  // Single-cycle ALU result plus its carry/overflow for opcodes 0000-0110
  always_comb begin
    aluRes = '0;
    aluV   = 1'b0;
    aluC   = 1'b0;
    case (opc)
      4'b0000: begin
        aluRes = sumW[DATA_W-1:0];
        aluC   = sumW[DATA_W];
        aluV   = (opA[MSB] == opB[MSB]) && (aluRes[MSB] != opA[MSB]);
      end
      4'b0001: begin
        aluRes = diffW;
        aluC   = (opA < opB);
        aluV   = (opA[MSB] != opB[MSB]) && (aluRes[MSB] != opA[MSB]);
      end
      4'b0010: aluRes = opA & opB;
      4'b0011: aluRes = opA | opB;
      4'b0100: aluRes = opA ^ opB;
      4'b0101: aluRes = ~opA;
      4'b0110: begin
        aluRes = {opA[DATA_W-2:0], 1'b0};
        aluC   = opA[MSB];
      end
      default: aluRes = '0;
    endcase
  end

  // Next-state logic: operand entry, execute, multiply sequencing and Clear
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    flags_d    = flags_q;
    lastMul_d  = lastMul_q;
    regs_d     = regs_q;
    mulAcc_d   = mulAcc_q;
    mulCand_d  = mulCand_q;
    mulPlier_d = mulPlier_q;
    mulCnt_d   = mulCnt_q;

    if (Clear) begin
      state_d    = ST_P0;
      flags_d    = 4'b0000;
      lastMul_d  = 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_d[i] = '0;
      end
      mulAcc_d   = '0;
      mulCand_d  = '0;
      mulPlier_d = '0;
      mulCnt_d   = '0;
    end else begin
      case (state_q)
        ST_P0: begin
          if (stepEvent) begin
            regs_d[0] = Sw;
            state_d   = ST_P1;
          end
        end
        ST_P1: begin
          if (stepEvent) begin
            regs_d[1] = Sw;
            state_d   = ST_P2;
          end
        end
        ST_P2: begin
          if (stepEvent) begin
            regs_d[2] = Sw;
            state_d   = ST_P3;
          end
        end
        ST_P3: begin
          if (stepEvent) begin
            state_d   = ST_P0;
            done_d    = 1'b1;
            lastMul_d = 1'b0;
            case (opc)
              4'b0000, 4'b0001, 4'b0010, 4'b0011,
              4'b0100, 4'b0101, 4'b0110: begin
                regs_d[3] = aluRes;
                flags_d   = {aluRes[MSB], (aluRes == '0), aluV, aluC};
              end
              4'b0111: begin
                state_d    = ST_MUL;
                done_d     = 1'b0;
                lastMul_d  = lastMul_q;
                mulAcc_d   = '0;
                mulCand_d  = {{DATA_W{1'b0}}, opA};
                mulPlier_d = opB;
                mulCnt_d   = '0;
              end
              4'b1110: regs_d[3] = regs_q[idx];
              4'b1111: regs_d[idx] = opB;
              default: regs_d[3] = regs_q[3];
            endcase
          end
        end
        ST_MUL: begin
          mulAcc_d   = mulAdd;
          mulCand_d  = {mulCand_q[2*DATA_W-2:0], 1'b0};
          mulPlier_d = {1'b0, mulPlier_q[DATA_W-1:1]};
          mulCnt_d   = mulCnt_q + CNT_W'(1);
          if (mulCnt_q == CNT_W'(DATA_W - 1)) begin
            regs_d[3] = mulAdd[DATA_W-1:0];
            regs_d[4] = mulAdd[2*DATA_W-1:DATA_W];
            flags_d   = {mulAdd[2*DATA_W-1], (mulAdd == '0), 1'b0,
                         (mulAdd[2*DATA_W-1:DATA_W] != '0)};
            lastMul_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_P0;
          end
        end
        default: state_d = ST_P0;
      endcase
    end
  end

  // All architectural state, cleared asynchronously by Reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_P0;
      stepPrev_q <= 1'b0;
      done_q     <= 1'b0;
      flags_q    <= 4'b0000;
      lastMul_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      mulAcc_q   <= '0;
      mulCand_q  <= '0;
      mulPlier_q <= '0;
      mulCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      stepPrev_q <= Step;
      done_q     <= done_d;
      flags_q    <= flags_d;
      lastMul_q  <= lastMul_d;
      regs_q     <= regs_d;
      mulAcc_q   <= mulAcc_d;
      mulCand_q  <= mulCand_d;
      mulPlier_q <= mulPlier_d;
      mulCnt_q   <= mulCnt_d;
    end
  end

  // Phase shows the entry step; the multiply keeps showing the execute phase
  always_comb begin
    Phase = 2'd0;
    case (state_q)
      ST_P0:   Phase = 2'd0;
      ST_P1:   Phase = 2'd1;
      ST_P2:   Phase = 2'd2;
      ST_P3:   Phase = 2'd3;
      ST_MUL:  Phase = 2'd3;
      default: Phase = 2'd0;
    endcase
  end

  // Result exposes the high half only after a completed multiply
  always_comb begin
    Busy        = (state_q == ST_MUL);
    Done        = done_q;
    Flags       = flags_q;
    Result      = lastMul_q ? {regs_q[4], regs_q[3]} : {{DATA_W{1'b0}}, regs_q[3]};
    Result_Disp = Show ? Result : '0;
  end

endmodule
